// File: rtl/led_matrix_pkg.sv
// Shared types for the 8x8 bicolor LED matrix driver/monitor pair.
// Latency: none (types and pure functions only); backpressure: n/a.
package led_matrix_pkg;
  localparam int ROWS = 8;
  localparam int COLS = 8;

  typedef logic [ROWS-1:0][COLS-1:0] matrix_t;

  typedef enum logic [1:0] {
    BLANK   = 2'd0,
    QUALIFY = 2'd1,
    HELD    = 2'd2
  } qual_state_t;

  // Row select is active-low, so a valid line has exactly one zero bit.
  function automatic logic is_onehot_low(input logic [7:0] row);
    return ($countones(~row) == 1);
  endfunction

  function automatic logic [2:0] row_index(input logic [7:0] row);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 0; i < ROWS; i++)
      if (!row[i]) idx = 3'(i);
    return idx;
  endfunction
endpackage

// File: rtl/led_matrix_scan_monitor_if.sv
// Matrix scan bus: column drives plus active-low row select.
// Latency: wires only; backpressure: none, the scan bus free-runs.
interface led_matrix_scan_monitor_if;
  logic [7:0] red_driver;
  logic [7:0] green_driver;
  logic [7:0] row_sink;

  modport master (output red_driver, green_driver, row_sink);
  modport slave  (input  red_driver, green_driver, row_sink);
endinterface

// File: rtl/led_matrix_scan_sync.sv
// 2-flop synchroniser plus stability qualifier for the scan bus.
// Latency: 2 sync + STABLE_CYCLES qualify; backpressure: none.
module led_matrix_scan_sync
  import led_matrix_pkg::*;
#(
  parameter int STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] red_driver,
  input  logic [7:0] green_driver,
  input  logic [7:0] row_sink,
  output logic       cap_valid,
  output logic [2:0] cap_row,
  output logic [7:0] cap_red,
  output logic [7:0] cap_green,
  output logic       multirow
);
  logic [7:0] m_row, m_red, m_green;
  logic [7:0] s_row, s_red, s_green;
  logic [7:0] c_row, c_red, c_green;
  logic [7:0] cnt;
  qual_state_t state;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_row   <= 8'hFF;
      m_red   <= 8'h00;
      m_green <= 8'h00;
      s_row   <= 8'hFF;
      s_red   <= 8'h00;
      s_green <= 8'h00;
    end else begin
      m_row   <= row_sink;
      m_red   <= red_driver;
      m_green <= green_driver;
      s_row   <= m_row;
      s_red   <= m_red;
      s_green <= m_green;
    end
  end

  logic match, done;
  assign match = ({s_row, s_red, s_green} == {c_row, c_red, c_green});
  // Qualification completes on the edge where the count would reach
  // STABLE_CYCLES, so the capture strobe is decoded from registered state.
  assign done = (state == QUALIFY) && match && (cnt == 8'(STABLE_CYCLES - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= BLANK;
      c_row   <= 8'hFF;
      c_red   <= 8'h00;
      c_green <= 8'h00;
      cnt     <= 8'd0;
    end else begin
      case (state)
        BLANK: begin
          if (s_row != 8'hFF) begin
            {c_row, c_red, c_green} <= {s_row, s_red, s_green};
            cnt   <= 8'd1;
            state <= QUALIFY;
          end
        end
        QUALIFY: begin
          if (!match) begin
            {c_row, c_red, c_green} <= {s_row, s_red, s_green};
            cnt <= 8'd1;
          end else if (done) begin
            state <= (c_row == 8'hFF) ? BLANK : HELD;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        HELD: begin
          if (!match) begin
            {c_row, c_red, c_green} <= {s_row, s_red, s_green};
            cnt   <= 8'd1;
            state <= (s_row == 8'hFF) ? BLANK : QUALIFY;
          end
        end
        default: state <= BLANK;
      endcase
    end
  end

  assign cap_valid = done && is_onehot_low(c_row);
  assign multirow  = done && (c_row != 8'hFF) && !is_onehot_low(c_row);
  assign cap_row   = row_index(c_row);
  assign cap_red   = c_red;
  assign cap_green = c_green;
endmodule

// File: rtl/led_matrix_scan_monitor.sv
// Rebuilds displayed 8x8 bicolor frames from the sampled scan bus.
// Latency: arrays update 1 clk after the completing capture; backpressure: none.
module led_matrix_scan_monitor
  import led_matrix_pkg::*;
#(
  parameter int STABLE_CYCLES = 4,
  parameter int FRAME_TIMEOUT = 1048576
) (
  input  logic                      clk,
  input  logic                      reset,
  led_matrix_scan_monitor_if.slave  scan,
  input  logic                      clear_err,
  output matrix_t                   red_array,
  output matrix_t                   green_array,
  output logic                      frame_valid,
  output logic [15:0]               frame_count,
  output logic [7:0]                row_seen,
  output logic                      err_multirow,
  output logic                      err_timeout
);
  localparam int TW = $clog2(FRAME_TIMEOUT + 1);

  logic       cap_valid, multirow;
  logic [2:0] cap_row;
  logic [7:0] cap_red, cap_green;

  led_matrix_scan_sync #(.STABLE_CYCLES(STABLE_CYCLES)) u_sync (
    .clk          (clk),
    .reset        (reset),
    .red_driver   (scan.red_driver),
    .green_driver (scan.green_driver),
    .row_sink     (scan.row_sink),
    .cap_valid    (cap_valid),
    .cap_row      (cap_row),
    .cap_red      (cap_red),
    .cap_green    (cap_green),
    .multirow     (multirow)
  );

  matrix_t       shadow_red, shadow_green;
  matrix_t       byp_red, byp_green;
  logic [7:0]    seen_next;
  logic [TW-1:0] tmo_cnt;
  logic          complete, timeout;

  // The completing row is still in flight to the shadow, so bypass it in.
  always_comb begin
    byp_red            = shadow_red;
    byp_green          = shadow_green;
    byp_red[cap_row]   = cap_red;
    byp_green[cap_row] = cap_green;
  end

  assign seen_next = row_seen | (8'h01 << cap_row);
  assign complete  = cap_valid && (seen_next == 8'hFF);
  assign timeout   = (row_seen != 8'h00) && (tmo_cnt == TW'(FRAME_TIMEOUT - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shadow_red   <= '0;
      shadow_green <= '0;
      red_array    <= '0;
      green_array  <= '0;
      row_seen     <= 8'h00;
      frame_valid  <= 1'b0;
      frame_count  <= 16'd0;
      tmo_cnt      <= '0;
      err_multirow <= 1'b0;
      err_timeout  <= 1'b0;
    end else begin
      frame_valid <= 1'b0;
      if (cap_valid) begin
        shadow_red[cap_row]   <= cap_red;
        shadow_green[cap_row] <= cap_green;
      end
      if (complete) begin
        red_array   <= byp_red;
        green_array <= byp_green;
        frame_valid <= 1'b1;
        frame_count <= frame_count + 16'd1;
        row_seen    <= 8'h00;
        tmo_cnt     <= '0;
      end else if (timeout) begin
        row_seen <= 8'h00;
        tmo_cnt  <= '0;
      end else begin
        if (cap_valid) row_seen <= seen_next;
        tmo_cnt <= (row_seen != 8'h00) ? tmo_cnt + 1'b1 : '0;
      end
      // New error conditions take priority over clear_err.
      err_multirow <= multirow | (err_multirow & ~clear_err);
      err_timeout  <= (timeout & ~complete) | (err_timeout & ~clear_err);
    end
  end
endmodule

// File: tb/tb_led_matrix_scan_monitor.sv
// Table-driven bench with a frame scoreboard for led_matrix_scan_monitor.
module tb_led_matrix_scan_monitor;
  import led_matrix_pkg::*;

  localparam int STABLE = 4;
  localparam int TMO    = 64;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic clear_err = 1'b0;
  always #5 clk = ~clk;

  led_matrix_scan_monitor_if scan_if ();

  matrix_t     red_array, green_array;
  logic        frame_valid;
  logic [15:0] frame_count;
  logic [7:0]  row_seen;
  logic        err_multirow, err_timeout;

  led_matrix_scan_monitor #(.STABLE_CYCLES(STABLE), .FRAME_TIMEOUT(TMO)) dut (
    .clk          (clk),
    .reset        (reset),
    .scan         (scan_if.slave),
    .clear_err    (clear_err),
    .red_array    (red_array),
    .green_array  (green_array),
    .frame_valid  (frame_valid),
    .frame_count  (frame_count),
    .row_seen     (row_seen),
    .err_multirow (err_multirow),
    .err_timeout  (err_timeout)
  );

  typedef struct {
    logic [7:0] row;
    logic [7:0] red;
    logic [7:0] green;
    logic [7:0] exp_seen;
  } vec_t;

  typedef struct {
    matrix_t     red;
    matrix_t     green;
    logic [15:0] cnt;
  } frame_t;

  int checks = 0;
  int errors = 0;
  frame_t sb_q[$];

  matrix_t     m_red, m_green;
  logic [7:0]  m_seen;
  logic [15:0] m_count;
  logic        prev_fv = 1'b0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_mat(input string name, input matrix_t act, input matrix_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_clear();
    m_red   = '0;
    m_green = '0;
    m_seen  = 8'h00;
    m_count = 16'd0;
    sb_q.delete();
  endtask

  task automatic idle_pins();
    scan_if.row_sink     = 8'hFF;
    scan_if.red_driver   = 8'h00;
    scan_if.green_driver = 8'h00;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b0;
    clear_err = 1'b0;
    idle_pins();
    model_clear();
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  // Drives one scan line and predicts its effect on the reconstructed frame.
  task automatic scan_line(input logic [7:0] row, input logic [7:0] red,
                           input logic [7:0] green, input int hold, input int gap);
    int zeros;
    int idx;
    frame_t f;
    zeros = 0;
    idx = 0;
    for (int b = 0; b < 8; b++)
      if (row[b] == 1'b0) begin zeros++; idx = b; end
    if (hold >= STABLE && zeros == 1) begin
      m_red[idx]   = red;
      m_green[idx] = green;
      m_seen[idx]  = 1'b1;
      if (m_seen == 8'hFF) begin
        m_count++;
        f.red = m_red; f.green = m_green; f.cnt = m_count;
        sb_q.push_back(f);
        m_seen = 8'h00;
      end
    end
    scan_if.row_sink     = row;
    scan_if.red_driver   = red;
    scan_if.green_driver = green;
    repeat (hold) @(posedge clk);
    #1 idle_pins();
    repeat (gap) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (reset) begin
      if (frame_valid) begin
        frame_t f;
        checks++;
        if (prev_fv) begin
          errors++;
          $display("FAIL fv_width: frame_valid high 2 cycles, required 1");
        end
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_frame: frame_valid with count %0d, none expected", frame_count);
        end else begin
          f = sb_q.pop_front();
          check_mat("sb_red", red_array, f.red);
          check_mat("sb_green", green_array, f.green);
          check("sb_count", frame_count, f.cnt);
        end
      end
      prev_fv = frame_valid;
    end else begin
      prev_fv = 1'b0;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t    diag[8];
    vec_t    rep[9];
    int      rep_rows[9];
    matrix_t diag_red, diag_green;

    for (int r = 0; r < 8; r++) begin
      diag[r].row      = ~(8'h01 << r);
      diag[r].red      = 8'h01 << r;
      diag[r].green    = ~(8'h01 << r);
      diag[r].exp_seen = (r == 7) ? 8'h00 : 8'((1 << (r + 1)) - 1);
      diag_red[r]      = 8'h01 << r;
      diag_green[r]    = ~(8'h01 << r);
    end
    rep_rows = '{0, 1, 2, 3, 3, 4, 5, 6, 7};
    for (int i = 0; i < 9; i++) begin
      rep[i].row      = ~(8'h01 << rep_rows[i]);
      rep[i].red      = 8'(rep_rows[i] * 17);
      rep[i].green    = 8'(~rep_rows[i]);
      rep[i].exp_seen = (i == 8) ? 8'h00 : 8'((1 << (rep_rows[i] + 1)) - 1);
    end
    rep[3].red = 8'hAA;
    rep[4].red = 8'h55;

    idle_pins();
    model_clear();
    do_reset();

    check_mat("rst_red", red_array, '0);
    check_mat("rst_green", green_array, '0);
    check("rst_count", frame_count, 16'd0);
    check("rst_seen", {8'h00, row_seen}, 16'h0000);
    check("rst_fv", {15'd0, frame_valid}, 16'd0);
    check("rst_errs", {14'd0, err_multirow, err_timeout}, 16'd0);

    // Diagonal frame, 6 cycles per row, 2 blank cycles between.
    for (int i = 0; i < 8; i++) begin
      scan_line(diag[i].row, diag[i].red, diag[i].green, 6, 2);
      check($sformatf("diag_seen%0d", i), {8'h00, row_seen}, {8'h00, diag[i].exp_seen});
    end
    check("diag_count", frame_count, 16'd1);
    check_mat("diag_red", red_array, diag_red);
    check("diag_errs", {14'd0, err_multirow, err_timeout}, 16'd0);

    // Partial frame then silence: timeout discards it and keeps old arrays.
    for (int r = 0; r < 7; r++)
      scan_line(~(8'h01 << r), 8'hFF, 8'h00, 6, 2);
    check("partial_seen", {8'h00, row_seen}, 16'h007F);
    repeat (40) @(posedge clk);
    #1;
    m_seen = 8'h00;
    check("tmo_err", {15'd0, err_timeout}, 16'd1);
    check("tmo_seen", {8'h00, row_seen}, 16'h0000);
    check("tmo_count", frame_count, 16'd1);
    check_mat("tmo_red", red_array, diag_red);
    check_mat("tmo_green", green_array, diag_green);
    clear_err = 1'b1;
    @(posedge clk); #1;
    clear_err = 1'b0;
    check("tmo_clear", {15'd0, err_timeout}, 16'd0);

    // Stability threshold: 3 cycles is ignored, 4 is captured 6 cycles after the pin.
    do_reset();
    scan_line(8'hFE, 8'h3C, 8'hC3, STABLE - 1, 10);
    check("short_seen", {8'h00, row_seen}, 16'h0000);
    scan_if.row_sink     = 8'hFE;
    scan_if.red_driver   = 8'h3C;
    scan_if.green_driver = 8'hC3;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("lat5_seen", {8'h00, row_seen}, 16'h0000);
    @(posedge clk);
    @(negedge clk);
    check("lat6_seen", {8'h00, row_seen}, 16'h0001);
    @(posedge clk); #1;
    idle_pins();

    // Two rows selected at once.
    do_reset();
    scan_line(8'hF3, 8'h12, 8'h34, 10, 4);
    check("multi_err", {15'd0, err_multirow}, 16'd1);
    check("multi_seen", {8'h00, row_seen}, 16'h0000);
    clear_err = 1'b1;
    @(posedge clk); #1;
    clear_err = 1'b0;
    check("multi_clear", {15'd0, err_multirow}, 16'd0);

    // Row 3 scanned twice: latest data wins.
    do_reset();
    for (int i = 0; i < 9; i++) begin
      scan_line(rep[i].row, rep[i].red, rep[i].green, 5, 1);
      check($sformatf("rep_seen%0d", i), {8'h00, row_seen}, {8'h00, rep[i].exp_seen});
    end
    check("rep_row3", {8'h00, red_array[3]}, 16'h0055);
    check("rep_count", frame_count, 16'd1);

    // Asynchronous reset in the middle of a frame.
    for (int r = 0; r < 4; r++)
      scan_line(~(8'h01 << r), 8'h0F, 8'hF0, 6, 2);
    check("mid_seen", {8'h00, row_seen}, 16'h000F);
    @(posedge clk); #3;
    reset = 1'b0;
    #1;
    check_mat("arst_red", red_array, '0);
    check_mat("arst_green", green_array, '0);
    check("arst_count", frame_count, 16'd0);
    check("arst_seen", {8'h00, row_seen}, 16'h0000);
    check("arst_flags", {13'd0, frame_valid, err_multirow, err_timeout}, 16'd0);
    model_clear();
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    for (int i = 0; i < 8; i++)
      scan_line(diag[i].row, diag[i].red, diag[i].green, 6, 2);
    check("post_rst_count", frame_count, 16'd1);

    repeat (5) @(posedge clk);
    #1;
    check("sb_empty", 16'(sb_q.size()), 16'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
